// File: rtl/ntps_cfg_pkg.sv
// Shared definitions for the ntps_cfg_regs AXI4-Lite configuration block:
// bus widths, register byte offsets, reset values, response codes,
// FSM state encodings and the address decoder.
package ntps_cfg_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned CFG1_W = 4;
    localparam int unsigned WORD_W = 30;

    // Register byte offsets
    localparam logic [7:0] OFF_VERSION = 8'h00;
    localparam logic [7:0] OFF_CTRL0   = 8'h04;
    localparam logic [7:0] OFF_CTRL1   = 8'h08;
    localparam logic [7:0] OFF_CTRL2   = 8'h0C;
    localparam logic [7:0] OFF_SCRATCH = 8'h10;

    // Reset values reproduce the constants these registers replaced
    localparam logic              RST_CFG0    = 1'b0;
    localparam logic [CFG1_W-1:0] RST_CFG1    = 4'h0;
    localparam logic              RST_CFG2    = 1'b0;
    localparam logic [DATA_W-1:0] RST_SCRATCH = 32'h0000_0000;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef enum logic [2:0] {
        SEL_VERSION,
        SEL_CTRL0,
        SEL_CTRL1,
        SEL_CTRL2,
        SEL_SCRATCH,
        SEL_NONE
    } reg_sel_e;

    // Map a 32-bit word index (byte address >> 2) to a register select
    function automatic reg_sel_e decode_addr(input logic [WORD_W-1:0] word);
        reg_sel_e sel;
        sel = SEL_NONE;
        if      (word == WORD_W'(OFF_VERSION[7:2])) sel = SEL_VERSION;
        else if (word == WORD_W'(OFF_CTRL0[7:2]))   sel = SEL_CTRL0;
        else if (word == WORD_W'(OFF_CTRL1[7:2]))   sel = SEL_CTRL1;
        else if (word == WORD_W'(OFF_CTRL2[7:2]))   sel = SEL_CTRL2;
        else if (word == WORD_W'(OFF_SCRATCH[7:2])) sel = SEL_SCRATCH;
        return sel;
    endfunction

endpackage

// File: rtl/ntps_cfg_regs_if.sv
// AXI4-Lite slave bus bundle for ntps_cfg_regs.
// master: drives aw*/w*/ar* payload+valid and bready/rready.
// slave : drives awready/wready/arready and the b*/r* response channels.
interface ntps_cfg_regs_if #(
    parameter int unsigned ADDR_W = 8
);
    import ntps_cfg_pkg::*;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [RESP_W-1:0] bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [RESP_W-1:0] rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/ntps_cfg_regs.sv
// ntps_cfg_regs: AXI4-Lite register block replacing hardwired tie-offs.
// Ports:
//   clk, areset_n   clock and asynchronous active-low reset
//   s_axi           AXI4-Lite slave (ntps_cfg_regs_if.slave)
//   cfg_dout0/1/2   register-driven configuration outputs
// Map: 0x00 VERSION (RO), 0x04 CTRL0[0], 0x08 CTRL1[3:0], 0x0C CTRL2[0],
//      0x10 SCRATCH (32-bit, byte strobes). Anything else -> SLVERR.
module ntps_cfg_regs
    import ntps_cfg_pkg::*;
#(
    parameter logic [31:0] CORE_VERSION = 32'h0001_0000,
    parameter int unsigned ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              areset_n,
    ntps_cfg_regs_if.slave    s_axi,
    output logic              cfg_dout0,
    output logic [CFG1_W-1:0] cfg_dout1,
    output logic              cfg_dout2
);

    wr_state_e w_state_q, w_state_nxt;
    rd_state_e r_state_q, r_state_nxt;

    logic              awready_q, wready_q, bvalid_q;
    logic [RESP_W-1:0] bresp_q;
    logic              arready_q, rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [RESP_W-1:0] rresp_q;
    logic [DATA_W-1:0] scratch_q;

    // Half of a write captured while waiting for the other channel
    logic [WORD_W-1:0] wr_word_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [STRB_W-1:0] wr_strb_q;

    logic              do_write_c, latch_addr_c, latch_data_c;
    logic [WORD_W-1:0] wr_word_c, aw_word_c, ar_word_c;
    logic [DATA_W-1:0] wr_data_c, rd_mux_c;
    logic [STRB_W-1:0] wr_strb_c;
    logic              aw_hs_c, w_hs_c, ar_hs_c;
    reg_sel_e          wr_sel_c, rd_sel_c;
    logic              unused_addr_lsb_c;

    assign aw_word_c = WORD_W'(s_axi.awaddr[ADDR_W-1:2]);
    assign ar_word_c = WORD_W'(s_axi.araddr[ADDR_W-1:2]);
    assign unused_addr_lsb_c = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign aw_hs_c = s_axi.awvalid && awready_q;
    assign w_hs_c  = s_axi.wvalid  && wready_q;
    assign ar_hs_c = s_axi.arvalid && arready_q;

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    // Write FSM state register
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) w_state_q <= W_IDLE;
        else           w_state_q <= w_state_nxt;
    end

    // Write FSM next state; merges live and latched halves on the second handshake
    always_comb begin
        w_state_nxt  = w_state_q;
        do_write_c   = 1'b0;
        latch_addr_c = 1'b0;
        latch_data_c = 1'b0;
        wr_word_c    = wr_word_q;
        wr_data_c    = wr_data_q;
        wr_strb_c    = wr_strb_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    do_write_c  = 1'b1;
                    wr_word_c   = aw_word_c;
                    wr_data_c   = s_axi.wdata;
                    wr_strb_c   = s_axi.wstrb;
                    w_state_nxt = W_RESP;
                end else if (aw_hs_c) begin
                    latch_addr_c = 1'b1;
                    w_state_nxt  = W_HAVE_ADDR;
                end else if (w_hs_c) begin
                    latch_data_c = 1'b1;
                    w_state_nxt  = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs_c) begin
                    do_write_c  = 1'b1;
                    wr_data_c   = s_axi.wdata;
                    wr_strb_c   = s_axi.wstrb;
                    w_state_nxt = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs_c) begin
                    do_write_c  = 1'b1;
                    wr_word_c   = aw_word_c;
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign wr_sel_c = decode_addr(wr_word_c);

    // Handshake flags registered from the next state so they track it exactly
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            awready_q <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_HAVE_DATA);
            wready_q  <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_HAVE_ADDR);
            bvalid_q  <= (w_state_nxt == W_RESP);
            if (do_write_c) bresp_q <= (wr_sel_c == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Capture whichever write channel arrives first
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_word_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else begin
            if (latch_addr_c) wr_word_q <= aw_word_c;
            if (latch_data_c) begin
                wr_data_q <= s_axi.wdata;
                wr_strb_q <= s_axi.wstrb;
            end
        end
    end

    // Register file; CTRL bits need byte lane 0, SCRATCH honours every lane
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cfg_dout0 <= RST_CFG0;
            cfg_dout1 <= RST_CFG1;
            cfg_dout2 <= RST_CFG2;
            scratch_q <= RST_SCRATCH;
        end else if (do_write_c) begin
            case (wr_sel_c)
                SEL_CTRL0: if (wr_strb_c[0]) cfg_dout0 <= wr_data_c[0];
                SEL_CTRL1: if (wr_strb_c[0]) cfg_dout1 <= wr_data_c[CFG1_W-1:0];
                SEL_CTRL2: if (wr_strb_c[0]) cfg_dout2 <= wr_data_c[0];
                SEL_SCRATCH: begin
                    for (int unsigned i = 0; i < STRB_W; i++) begin
                        if (wr_strb_c[i]) scratch_q[8*i +: 8] <= wr_data_c[8*i +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) r_state_q <= R_IDLE;
        else           r_state_q <= r_state_nxt;
    end

    // Read FSM next state
    always_comb begin
        r_state_nxt = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs_c) r_state_nxt = R_DATA;
            R_DATA:  if (s_axi.rready) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign rd_sel_c = decode_addr(ar_word_c);

    // Read mux sees pre-edge register values, so a colliding write is not visible
    always_comb begin
        rd_mux_c = '0;
        case (rd_sel_c)
            SEL_VERSION: rd_mux_c = CORE_VERSION;
            SEL_CTRL0:   rd_mux_c = DATA_W'(cfg_dout0);
            SEL_CTRL1:   rd_mux_c = DATA_W'(cfg_dout1);
            SEL_CTRL2:   rd_mux_c = DATA_W'(cfg_dout2);
            SEL_SCRATCH: rd_mux_c = scratch_q;
            default:     rd_mux_c = '0;
        endcase
    end

    // Read response registers, held until rready
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            arready_q <= (r_state_nxt == R_IDLE);
            rvalid_q  <= (r_state_nxt == R_DATA);
            if (ar_hs_c) begin
                rdata_q <= rd_mux_c;
                rresp_q <= (rd_sel_c == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_ntps_cfg_regs.sv
// Directed self-checking bench for ntps_cfg_regs.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_ntps_cfg_regs;
    import ntps_cfg_pkg::*;

    logic clk = 1'b0;
    logic areset_n;
    logic cfg_dout0, cfg_dout2;
    logic [3:0] cfg_dout1;

    int n_cmp = 0;
    int n_bad = 0;

    ntps_cfg_regs_if #(.ADDR_W(8)) bus ();

    ntps_cfg_regs #(
        .CORE_VERSION(32'h0001_0000),
        .ADDR_W(8)
    ) dut (
        .clk(clk),
        .areset_n(areset_n),
        .s_axi(bus),
        .cfg_dout0(cfg_dout0),
        .cfg_dout1(cfg_dout1),
        .cfg_dout2(cfg_dout2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cfg(input string tag, input logic d0, input logic [3:0] d1, input logic d2);
        chk({tag, "_cfg0"}, 32'(cfg_dout0), 32'(d0));
        chk({tag, "_cfg1"}, 32'(cfg_dout1), 32'(d1));
        chk({tag, "_cfg2"}, 32'(cfg_dout2), 32'(d2));
    endtask

    task automatic do_read(input string tag, input logic [7:0] addr,
                           input logic [31:0] exp_d, input logic [1:0] exp_r);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        chk({tag, "_arready"}, 32'(bus.arready), 32'd1);
        step();
        bus.arvalid = 1'b0;
        chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
        chk({tag, "_rdata"}, bus.rdata, exp_d);
        chk({tag, "_rresp"}, 32'(bus.rresp), 32'(exp_r));
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        chk({tag, "_rvalid_drop"}, 32'(bus.rvalid), 32'd0);
    endtask

    // AW and W presented together; completes on the first edge
    task automatic do_write(input string tag, input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_r);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        step();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(bus.bresp), 32'(exp_r));
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        chk({tag, "_bvalid_drop"}, 32'(bus.bvalid), 32'd0);
    endtask

    initial begin
        areset_n    = 1'b0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_bresp", 32'(bus.bresp), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_awready", 32'(bus.awready), 32'd1);
        chk("rst_wready", 32'(bus.wready), 32'd1);
        chk("rst_arready", 32'(bus.arready), 32'd1);
        chk_cfg("rst", 1'b0, 4'h0, 1'b0);
        areset_n = 1'b1;
        step();

        // VERSION read after reset
        do_read("ver", 8'h00, 32'h0001_0000, 2'b00);
        chk_cfg("ver", 1'b0, 4'h0, 1'b0);

        // AW first, W three cycles later, CTRL1 <= 0xA
        bus.awaddr  = 8'h08;
        bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        chk("aw1_awready", 32'(bus.awready), 32'd0);
        chk("aw1_wready", 32'(bus.wready), 32'd1);
        chk("aw1_bvalid", 32'(bus.bvalid), 32'd0);
        step();
        step();
        bus.wdata  = 32'h0000_000A;
        bus.wstrb  = 4'h1;
        bus.wvalid = 1'b1;
        chk("aw1_cfg1_before", 32'(cfg_dout1), 32'h0);
        step();
        bus.wvalid = 1'b0;
        chk("aw1_cfg1_after", 32'(cfg_dout1), 32'hA);
        chk("aw1_bvalid", 32'(bus.bvalid), 32'd1);
        chk("aw1_bresp", 32'(bus.bresp), 32'd0);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        chk("aw1_bvalid_drop", 32'(bus.bvalid), 32'd0);
        chk("aw1_awready_back", 32'(bus.awready), 32'd1);
        do_read("ctrl1", 8'h08, 32'h0000_000A, 2'b00);

        // W first, then AW; SCRATCH lanes 0 and 2; bready held off
        bus.wdata  = 32'hDEAD_BEEF;
        bus.wstrb  = 4'b0101;
        bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        chk("w1_wready", 32'(bus.wready), 32'd0);
        chk("w1_awready", 32'(bus.awready), 32'd1);
        chk("w1_bvalid", 32'(bus.bvalid), 32'd0);
        bus.awaddr  = 8'h10;
        bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        chk("w1_bvalid", 32'(bus.bvalid), 32'd1);
        chk("w1_bresp", 32'(bus.bresp), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("w1_bvalid_hold", 32'(bus.bvalid), 32'd1);
            chk("w1_bresp_hold", 32'(bus.bresp), 32'd0);
        end
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        chk("w1_bvalid_drop", 32'(bus.bvalid), 32'd0);
        do_read("scratch", 8'h10, 32'h00AD_00EF, 2'b00);

        // Unmapped write and read
        do_write("unm_wr", 8'h14, 32'h0000_0001, 4'hF, 2'b10);
        chk_cfg("unm_wr", 1'b0, 4'hA, 1'b0);
        do_read("unm_rd", 8'h40, 32'h0000_0000, 2'b10);
        do_read("scratch2", 8'h10, 32'h00AD_00EF, 2'b00);

        // Write ignored without lane 0; VERSION write ignored with OKAY
        do_write("nostrb", 8'h08, 32'h0000_0005, 4'hE, 2'b00);
        chk("nostrb_cfg1", 32'(cfg_dout1), 32'hA);
        do_write("verwr", 8'h00, 32'h1234_5678, 4'hF, 2'b00);
        do_read("ver2", 8'h00, 32'h0001_0000, 2'b00);

        // Unused CTRL bits read as zero
        do_write("ctrl2", 8'h0C, 32'hFFFF_FFFF, 4'hF, 2'b00);
        chk("ctrl2_cfg2", 32'(cfg_dout2), 32'd1);
        do_read("ctrl2_rd", 8'h0C, 32'h0000_0001, 2'b00);

        // Write and read of CTRL0 on the same edge: read returns old value
        bus.awaddr  = 8'h04;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'h0000_0001;
        bus.wstrb   = 4'h1;
        bus.wvalid  = 1'b1;
        bus.araddr  = 8'h04;
        bus.arvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        chk("coll_rvalid", 32'(bus.rvalid), 32'd1);
        chk("coll_rdata", bus.rdata, 32'd0);
        chk("coll_bvalid", 32'(bus.bvalid), 32'd1);
        chk("coll_cfg0", 32'(cfg_dout0), 32'd1);
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        step();
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        chk("coll_bvalid_drop", 32'(bus.bvalid), 32'd0);
        chk("coll_rvalid_drop", 32'(bus.rvalid), 32'd0);
        chk_cfg("coll", 1'b1, 4'hA, 1'b1);

        // Reset between AW and W aborts the write
        bus.awaddr  = 8'h08;
        bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        chk("abort_awready", 32'(bus.awready), 32'd0);
        #2;
        areset_n = 1'b0;
        #1;
        chk_cfg("abort_async", 1'b0, 4'h0, 1'b0);
        chk("abort_awready_rst", 32'(bus.awready), 32'd1);
        step();
        areset_n = 1'b1;
        bus.wdata  = 32'h0000_0007;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_bvalid", 32'(bus.bvalid), 32'd0);
            step();
        end
        chk_cfg("abort_end", 1'b0, 4'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ntps_cfg_regs.md
NTPS_CFG_REGS -- requirements
Module: ntps_cfg_regs

Interface
REQ-001 SHALL have parameter CORE_VERSION, default 32'h0001_0000, value returned by VERSION register.
REQ-002 SHALL have parameter ADDR_W, default 8, AXI4-Lite byte-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port areset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel.
REQ-006 SHALL have ports s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
REQ-007 SHALL have ports s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-008 SHALL have ports s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel.
REQ-009 SHALL have ports s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
REQ-010 SHALL have ports cfg_dout0  output 1, cfg_dout1  output 4, cfg_dout2  output 1: software-writable replacements for hardwired tie-off constants, driven from registers.

Function
REQ-011 Register map (addr[ADDR_W-1:2] decode, addr[1:0] ignored): 0x00 VERSION RO; 0x04 CTRL0 bit0->cfg_dout0; 0x08 CTRL1 bits3:0->cfg_dout1; 0x0C CTRL2 bit0->cfg_dout2; 0x10 SCRATCH 32-bit RW.
REQ-012 CTRL writes SHALL take effect only when wstrb[0]=1; SCRATCH SHALL honour each wstrb lane independently.
REQ-013 Unused CTRL bits SHALL read 0; VERSION writes SHALL be ignored, response OKAY.
REQ-014 Unmapped addresses: reads SHALL return 0 with rresp=SLVERR(2'b10); writes SHALL change nothing, bresp=SLVERR.
REQ-015 Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
REQ-016 awready SHALL be 1 in W_IDLE and W_HAVE_DATA only; wready SHALL be 1 in W_IDLE and W_HAVE_ADDR only.
REQ-017 AW and W SHALL be accepted in either order or the same cycle; register update SHALL occur on the edge completing the second handshake, FSM -> W_RESP.
REQ-018 bvalid SHALL assert the cycle after the update and hold with stable bresp until bready; on bvalid&&bready FSM -> W_IDLE.
REQ-019 Read FSM states: R_IDLE, R_DATA; arready=1 only in R_IDLE.
REQ-020 On arvalid&&arready, rdata/rresp SHALL be registered and rvalid asserted the next cycle (1-cycle latency), held stable until rready.
REQ-021 Read and write to same register completing the same edge: read SHALL return pre-write value.
REQ-022 cfg_dout* SHALL change on the update edge, glitch-free (direct register outputs).
REQ-023 Read and write channels SHALL operate concurrently and independently.

Reset
REQ-024 areset_n low SHALL asynchronously clear cfg_dout0=0, cfg_dout1=4'h0, cfg_dout2=0, SCRATCH=0, matching former tie-off values.
REQ-025 Reset SHALL force W_IDLE, R_IDLE, bvalid=0, rvalid=0, bresp=rresp=0, rdata=0.
REQ-026 Reset mid-transaction SHALL abort it with no register update and no response after release.
REQ-027 Reset deassertion need not be synchronised inside the block; the integrator supplies a synchronously released areset_n.

Structure
REQ-028 Package ntps_cfg_pkg SHALL hold address offsets, reset values, RESP_OKAY/RESP_SLVERR and FSM state enums.
REQ-029 Single flat module; no sub-module is warranted.

Verification
REQ-030 Reset release, read 0x00 -> rdata=32'h0001_0000, rresp=0; all cfg_dout*=0.
REQ-031 AW one cycle, W three cycles later, data 0xA, wstrb 4'h1 to 0x08 -> cfg_dout1=4'hA on second-handshake edge, bvalid next cycle, bresp=0.
REQ-032 W before AW, 0xDEADBEEF wstrb 4'b0101 to 0x10 -> readback 0x00AD00EF; bready held low 5 cycles -> bvalid stays high, bresp stable.
REQ-033 Write 0x1 to 0x14, read 0x40 -> bresp=2'b10, rdata=0, rresp=2'b10, no output changes.
REQ-034 Simultaneous write 0x1 to 0x04 and read 0x04 same edge -> rdata=0, cfg_dout0=1 afterwards.
REQ-035 Assert areset_n low after AW accepted, before W -> after release cfg_dout* unchanged from reset, bvalid never asserts.
